// File: rtl/rtc_date_reader.sv
// Reads the day, month and year BCD bytes from the RTC over its multiplexed address/data bus.
// The display registers change only after a complete burst in which every fetched nibble is valid BCD.
module rtc_date_reader #(
  parameter int          PW         = 4,
  parameter int          GAP        = 2,
  parameter int          REFRESH    = 50000,
  parameter logic [7:0]  ADDR_DAY   = 8'h24,
  parameter logic [7:0]  ADDR_MONTH = 8'h25,
  parameter logic [7:0]  ADDR_YEAR  = 8'h26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       ad_sel,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] fecha_day,
  output logic [7:0] fecha_month,
  output logic [7:0] fecha_year,
  output logic       date_valid,
  output logic       busy,
  output logic       done,
  output logic       bcd_err
);

  localparam int             RW       = (REFRESH > 2) ? $clog2(REFRESH) : 1;
  localparam logic [RW-1:0]  REF_LAST = RW'((REFRESH > 0) ? REFRESH - 1 : 0);
  localparam logic [3:0]     PW_LAST  = 4'(PW - 1);
  localparam logic [3:0]     GAP_LAST = 4'(GAP - 1);

  typedef enum logic [2:0] {IDLE, ADDR, GAP_A, DATA, GAP_D, COMMIT} state_t;

  state_t        state;
  logic [3:0]    ph_cnt;
  logic [1:0]    idx;
  logic [RW-1:0] ref_cnt;
  logic [7:0]    shadow_day, shadow_month, shadow_year;
  logic          trigger;

  function automatic logic bcd_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] addr_of(input logic [1:0] i);
    case (i)
      2'd0:    return ADDR_DAY;
      2'd1:    return ADDR_MONTH;
      default: return ADDR_YEAR;
    endcase
  endfunction

  assign trigger = start || ((REFRESH != 0) && (ref_cnt == REF_LAST));

  // Strobes are set on the edge that enters a phase, so each output is stable for the whole phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ph_cnt      <= 4'd0;
      idx         <= 2'd0;
      ref_cnt     <= '0;
      ad_out      <= 8'h00;
      ad_oe       <= 1'b0;
      cs_n        <= 1'b1;
      ad_sel      <= 1'b0;
      wr_n        <= 1'b1;
      rd_n        <= 1'b1;
      fecha_day   <= 8'h00;
      fecha_month <= 8'h00;
      fecha_year  <= 8'h00;
      date_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd_err     <= 1'b0;
    end else begin
      done    <= 1'b0;
      bcd_err <= 1'b0;
      ph_cnt  <= ph_cnt + 4'd1;
      case (state)
        IDLE: begin
          if (trigger) begin
            ref_cnt <= '0;
            idx     <= 2'd0;
            ph_cnt  <= 4'd0;
            state   <= ADDR;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            wr_n    <= 1'b0;
            ad_oe   <= 1'b1;
            ad_sel  <= 1'b0;
            ad_out  <= ADDR_DAY;
          end else begin
            ref_cnt <= ref_cnt + RW'(1);
          end
        end
        ADDR: begin
          if (ph_cnt == PW_LAST) begin
            ph_cnt <= 4'd0;
            state  <= GAP_A;
            cs_n   <= 1'b1;
            wr_n   <= 1'b1;
            ad_oe  <= 1'b0;
          end
        end
        GAP_A: begin
          if (ph_cnt == GAP_LAST) begin
            ph_cnt <= 4'd0;
            state  <= DATA;
            cs_n   <= 1'b0;
            ad_sel <= 1'b1;
            rd_n   <= 1'b0;
          end
        end
        DATA: begin
          if (ph_cnt == PW_LAST) begin
            ph_cnt <= 4'd0;
            state  <= GAP_D;
            cs_n   <= 1'b1;
            rd_n   <= 1'b1;
            ad_sel <= 1'b0;
          end
        end
        GAP_D: begin
          if (ph_cnt == GAP_LAST) begin
            ph_cnt <= 4'd0;
            if (idx == 2'd2) begin
              state <= COMMIT;
            end else begin
              idx    <= idx + 2'd1;
              state  <= ADDR;
              cs_n   <= 1'b0;
              wr_n   <= 1'b0;
              ad_oe  <= 1'b1;
              ad_out <= addr_of(idx + 2'd1);
            end
          end
        end
        COMMIT: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (bcd_ok(shadow_day) && bcd_ok(shadow_month) && bcd_ok(shadow_year)) begin
            fecha_day   <= shadow_day;
            fecha_month <= shadow_month;
            fecha_year  <= shadow_year;
            date_valid  <= 1'b1;
          end else begin
            bcd_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shadow bytes are pure data; a stale value is never published because COMMIT follows three fresh captures.
  always_ff @(posedge clk) begin
    if (state == DATA && ph_cnt == PW_LAST) begin
      case (idx)
        2'd0:    shadow_day   <= ad_in;
        2'd1:    shadow_month <= ad_in;
        default: shadow_year  <= ad_in;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_date_reader.sv
// Bench for rtc_date_reader: one instance with auto refresh disabled for directed and random bursts,
// a second with REFRESH = 100 for the periodic timing.
module tb_rtc_date_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset0 = 1'b1, start0 = 1'b0;
  logic       reset1 = 1'b1, start1 = 1'b0;
  logic [7:0] ad_in0, ad_out0, fd0, fm0, fy0;
  logic [7:0] ad_in1, ad_out1, fd1, fm1, fy1;
  logic       ad_oe0, cs_n0, ad_sel0, wr_n0, rd_n0, dv0, busy0, done0, err0;
  logic       ad_oe1, cs_n1, ad_sel1, wr_n1, rd_n1, dv1, busy1, done1, err1;

  rtc_date_reader #(.REFRESH(0)) dut0 (
    .clk(clk), .reset(reset0), .start(start0), .ad_in(ad_in0), .ad_out(ad_out0),
    .ad_oe(ad_oe0), .cs_n(cs_n0), .ad_sel(ad_sel0), .wr_n(wr_n0), .rd_n(rd_n0),
    .fecha_day(fd0), .fecha_month(fm0), .fecha_year(fy0), .date_valid(dv0),
    .busy(busy0), .done(done0), .bcd_err(err0));

  rtc_date_reader #(.REFRESH(100)) dut1 (
    .clk(clk), .reset(reset1), .start(start1), .ad_in(ad_in1), .ad_out(ad_out1),
    .ad_oe(ad_oe1), .cs_n(cs_n1), .ad_sel(ad_sel1), .wr_n(wr_n1), .rd_n(rd_n1),
    .fecha_day(fd1), .fecha_month(fm1), .fecha_year(fy1), .date_valid(dv1),
    .busy(busy1), .done(done1), .bcd_err(err1));

  // RTC models: latch the address during a write strobe, return the addressed register.
  logic [7:0] mem0 [0:255];
  logic [7:0] mem1 [0:255];
  logic [7:0] lat0 = 8'h00, lat1 = 8'h00;
  always @(posedge clk) if (!cs_n0 && !wr_n0) lat0 <= ad_out0;
  always @(posedge clk) if (!cs_n1 && !wr_n1) lat1 <= ad_out1;
  assign ad_in0 = mem0[lat0];
  assign ad_in1 = mem1[lat1];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("proto0", {30'd0, (wr_n0 | rd_n0), (ad_oe0 ? (!wr_n0 && !cs_n0) : 1'b1)}, 32'd3);
    chk("proto1", {30'd0, (wr_n1 | rd_n1), (ad_oe1 ? (!wr_n1 && !cs_n1) : 1'b1)}, 32'd3);
    chk("err_wo_done0", {31'd0, err0 & ~done0}, 32'd0);
  end

  // Reference model: what the display should show after each burst.
  logic [7:0] e_day = 8'h00, e_mon = 8'h00, e_year = 8'h00;
  logic       e_valid = 1'b0;

  function automatic bit bcd_ok_m(input int b);
    return ((b / 16) <= 9) && ((b % 16) <= 9);
  endfunction

  function automatic logic [7:0] rnd_byte();
    int v;
    if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 255);
    else v = $urandom_range(0, 9) * 16 + $urandom_range(0, 9);
    return 8'(v);
  endfunction

  task automatic check_pub0(input string tag);
    chk({tag, "_day"},   fd0, e_day);
    chk({tag, "_month"}, fm0, e_mon);
    chk({tag, "_year"},  fy0, e_year);
    chk({tag, "_valid"}, dv0, e_valid);
  endtask

  task automatic burst0(input logic [7:0] d, m, y, input bit retrig);
    int         ndone = 0, done_k = -1, wr_low = 0, rd_low = 0, hi_run = 0;
    logic       err_at = 1'b0, prev_wr = 1'b1;
    logic [7:0] addrs[$];
    logic [7:0] exp_a [3];
    bit         exp_err;
    exp_a = '{8'h24, 8'h25, 8'h26};
    mem0[8'h24] = d; mem0[8'h25] = m; mem0[8'h26] = y;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("busy_rise", busy0, 1);
    for (int k = 0; k < 46; k++) begin
      if (!wr_n0) begin
        wr_low++;
        if (prev_wr) addrs.push_back(ad_out0);
      end
      prev_wr = wr_n0;
      if (!rd_n0) rd_low++;
      if (done0) begin ndone++; done_k = k; err_at = err0; end
      if (busy0 && cs_n0) hi_run++;
      else begin
        if (!cs_n0 && hi_run > 0) chk("cs_gap0", {31'd0, hi_run >= 2}, 1);
        hi_run = 0;
      end
      start0 = (retrig && k == 10);
      @(negedge clk);
    end
    start0 = 1'b0;
    exp_err = !(bcd_ok_m(d) && bcd_ok_m(m) && bcd_ok_m(y));
    if (!exp_err) begin e_day = d; e_mon = m; e_year = y; e_valid = 1'b1; end
    chk("done_count", ndone, 1);
    chk("done_latency", done_k, 37);
    chk("bcd_err_at_done", err_at, exp_err);
    chk("wr_low_cycles", wr_low, 12);
    chk("rd_low_cycles", rd_low, 12);
    chk("addr_count", addrs.size(), 3);
    if (addrs.size() == 3)
      for (int i = 0; i < 3; i++) chk("addr_seq", addrs[i], exp_a[i]);
    chk("busy_after", busy0, 0);
    check_pub0("pub");
  endtask

  initial begin
    int seen;
    int rises[$];
    logic prev_b;
    int hi_run;

    mem1[8'h24] = 8'h05; mem1[8'h25] = 8'h12; mem1[8'h26] = 8'h99;

    // Reset held with start asserted.
    start0 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_busy", busy0, 0);
      chk("rst_strobes", {29'd0, cs_n0, wr_n0, rd_n0}, 32'd7);
    end
    chk("rst_ad_out", ad_out0, 0);
    chk("rst_ad_oe", ad_oe0, 0);
    chk("rst_ad_sel", ad_sel0, 0);
    chk("rst_done_err", {30'd0, done0, err0}, 0);
    check_pub0("rst");
    reset0 = 1'b0;
    start0 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_no_refresh", busy0, 0);
    end

    // Directed bursts: valid date, then an invalid month.
    burst0(8'h21, 8'h09, 8'h16, 1'b0);
    chk("first_day", fd0, 8'h21);
    burst0(8'h21, 8'h3A, 8'h16, 1'b0);
    chk("kept_month", fm0, 8'h09);

    for (int i = 0; i < 6; i++) burst0(rnd_byte(), rnd_byte(), rnd_byte(), 1'b0);

    // start during a burst is neither honoured nor queued.
    burst0(8'h07, 8'h11, 8'h23, 1'b1);
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy0) seen++;
    end
    chk("no_extra_burst", seen, 0);

    // Reset in the second DATA phase abandons the burst.
    begin
      int   runs = 0;
      logic prev_rd = 1'b1;
      bit   hit = 0;
      mem0[8'h24] = 8'h01; mem0[8'h25] = 8'h02; mem0[8'h26] = 8'h03;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (!rd_n0 && prev_rd) runs++;
        prev_rd = rd_n0;
        if (runs == 2 && !rd_n0) begin hit = 1; break; end
        @(negedge clk);
      end
      chk("reached_data2", hit, 1);
      reset0 = 1'b1;
      @(negedge clk);
      e_day = 8'h00; e_mon = 8'h00; e_year = 8'h00; e_valid = 1'b0;
      chk("mid_rst_strobes", {30'd0, cs_n0, rd_n0}, 32'd3);
      chk("mid_rst_oe", ad_oe0, 0);
      chk("mid_rst_busy", busy0, 0);
      chk("mid_rst_done", done0, 0);
      check_pub0("mid_rst");
      @(negedge clk);
      chk("mid_rst_done2", done0, 0);
      reset0 = 1'b0;
    end

    // Periodic refresh on the second instance.
    reset1 = 1'b0;
    prev_b = 1'b0;
    hi_run = 0;
    for (int k = 1; k <= 520; k++) begin
      @(negedge clk);
      if (busy1 && !prev_b) rises.push_back(k);
      prev_b = busy1;
      if (busy1 && cs_n1) hi_run++;
      else begin
        if (!cs_n1 && hi_run > 0) chk("cs_gap1", {31'd0, hi_run >= 2}, 1);
        hi_run = 0;
      end
    end
    chk("refresh_bursts", rises.size(), 4);
    if (rises.size() >= 1) chk("refresh_first", rises[0], 100);
    for (int i = 1; i < rises.size(); i++) chk("refresh_period", rises[i] - rises[i-1], 137);
    chk("refresh_pub", {8'd0, fd1, fm1, fy1}, 32'h00051299);
    chk("refresh_valid", dv1, 1);
    chk("refresh_start_unused", start1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
